phase_timing_sequencer: RTL and testbench
=========================================

PHASE_TIMING_SEQUENCER -- requirements
Module: phase_timing_sequencer

Interface
REQ-001 Parameter NUM_PHASES, default 12, SHALL set the number of phases in one bus-transaction sequence (range 2..16).
REQ-002 Parameter CNT_W, default 6, SHALL set the width of the per-phase cycle counter and duration entries.
REQ-003 Parameter IDX_W, default 4, SHALL set the phase index width; NUM_PHASES <= 2^IDX_W.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 req_wr  input  1  SHALL be the level write-sequence request.
REQ-007 req_rd  input  1  SHALL be the level read-sequence request.
REQ-008 dur_we  input  1  SHALL write dur_data into duration entry dur_addr on the rising edge.
REQ-009 dur_addr  input  IDX_W  SHALL select the duration entry; addresses >= NUM_PHASES are ignored.
REQ-010 dur_data  input  CNT_W  SHALL be the duration value: the phase lasts dur_data+1 cycles.
REQ-011 phase  output  IDX_W  SHALL be the current phase index.
REQ-012 phase_cnt  output  CNT_W  SHALL be the cycle count within the current phase.
REQ-013 busy  output  1  SHALL be high while a sequence runs.
REQ-014 mode  output  1  SHALL be the active sequence type (0 write, 1 read).
REQ-015 phase_start  output  1  SHALL be high when busy=1 and phase_cnt=0.
REQ-016 cycle_done  output  1  SHALL pulse one cycle per completed sequence.

Function
REQ-017 Requests SHALL be prioritised: req_wr beats req_rd; the active request is req = req_wr|req_rd, the requested mode is ~req_wr & req_rd.
REQ-018 States SHALL be IDLE (busy=0), RUN (busy=1) and, with the macro of REQ-031 defined, HOLD (busy=0, cycle_done already issued).
REQ-019 IDLE with req=1 SHALL load phase=0, phase_cnt=0, mode=requested mode, busy=1 on the same edge (RUN).
REQ-020 In RUN, phase_cnt SHALL increment each edge while phase_cnt < dur[phase].
REQ-021 When phase_cnt >= dur[phase] (>= so a shortened entry still ends the phase), the edge SHALL clear phase_cnt and advance phase by 1.
REQ-022 At termination of phase NUM_PHASES-1, phase SHALL wrap to 0 and cycle_done SHALL be 1 in the following cycle only.
REQ-023 req=0 in RUN SHALL abort on the next edge: phase=0, phase_cnt=0, busy=0, no cycle_done.
REQ-024 Requested mode differing from mode in RUN SHALL restart on the next edge: phase=0, phase_cnt=0, mode updated, busy=1, no cycle_done.
REQ-025 dur_we SHALL be honoured in every state; a write to the running phase's entry SHALL affect the compare from the next cycle.
REQ-026 Abort/restart and phase termination on the same edge SHALL resolve as abort/restart; cycle_done SHALL NOT assert.
REQ-027 Default sequence length SHALL be 272 cycles (sum of dur+1 over the REQ-029 table).

Reset
REQ-028 Reset SHALL force phase=0, phase_cnt=0, busy=0, mode=0, cycle_done=0, state IDLE, asynchronously, including mid-sequence.
REQ-029 Reset SHALL load duration entries 0..11 with 20,20,20,10,10,20,60,20,10,10,50,10 and entries 12..NUM_PHASES-1 with 20.
REQ-030 First RUN after reset release SHALL start at phase 0 regardless of prior activity.

Configuration
REQ-031 Macro PHASE_SEQ_ONESHOT_EN defined: after cycle_done the block SHALL enter HOLD (phase=0, phase_cnt=0) until req=0, then IDLE; a mode change in HOLD SHALL start a new RUN.
REQ-032 Macro not defined: RUN SHALL wrap continuously, one cycle_done per completed sequence, while req=1.

Verification
REQ-033 Reset release, req_wr=1 held, defaults -> phase 0 for 21 cycles, phase 6 for 61 cycles, cycle_done at cycle 272, mode=0.
REQ-034 req_rd=1 running, at phase 3 cnt 5 assert req_wr -> next edge phase=0, cnt=0, mode=0, busy=1, no cycle_done.
REQ-035 req_wr dropped at phase 10 cnt 30 -> next edge busy=0, phase=0, cnt=0; reasserted -> restarts at phase 0.
REQ-036 dur entry 6 written 5 while phase 6 cnt=40 -> phase 7 on next edge; entry 0 written 3 -> phase 0 lasts 4 cycles thereafter.
REQ-037 PHASE_SEQ_ONESHOT_EN defined, req_rd held -> single cycle_done at 272, busy=0 thereafter; undefined -> cycle_done at 272 and 544.
REQ-038 reset asserted mid-edge-free interval at phase 8 -> outputs cleared immediately without a clock edge; durations back to defaults.

Source files
------------

// File: rtl/phase_timing_sequencer.sv
// Phase timing sequencer: steps through NUM_PHASES programmable-length phases per bus transaction.
// Define PHASE_SEQ_ONESHOT_EN to stop in HOLD after one sequence instead of wrapping continuously.
module phase_timing_sequencer #(
  parameter int NUM_PHASES = 12,
  parameter int CNT_W      = 6,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_wr,
  input  logic             req_rd,
  input  logic             dur_we,
  input  logic [IDX_W-1:0] dur_addr,
  input  logic [CNT_W-1:0] dur_data,
  output logic [IDX_W-1:0] phase,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             busy,
  output logic             mode,
  output logic             phase_start,
  output logic             cycle_done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] dur_q [NUM_PHASES];
  logic [CNT_W-1:0] dur_d [NUM_PHASES];

  logic req;
  logic req_mode;
  logic phase_end;

  function automatic logic [CNT_W-1:0] default_dur(input int idx);
    case (idx)
      3, 4, 8, 9, 11: return CNT_W'(10);
      6:              return CNT_W'(60);
      10:             return CNT_W'(50);
      default:        return CNT_W'(20);
    endcase
  endfunction

  assign req       = req_wr | req_rd;
  assign req_mode  = ~req_wr & req_rd;
  // >= rather than == so an entry shortened below the running count still ends the phase
  assign phase_end = (cnt_q >= dur_q[phase_q]);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    dur_d   = dur_q;

    if (dur_we && (32'(dur_addr) < NUM_PHASES)) begin
      dur_d[dur_addr] = dur_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_RUN;
          phase_d = '0;
          cnt_d   = '0;
          mode_d  = req_mode;
        end
      end
      ST_RUN: begin
        if (!req) begin
          state_d = ST_IDLE;
          phase_d = '0;
          cnt_d   = '0;
        end else if (req_mode != mode_q) begin
          phase_d = '0;
          cnt_d   = '0;
          mode_d  = req_mode;
        end else if (phase_end) begin
          cnt_d = '0;
          if (phase_q == IDX_W'(NUM_PHASES - 1)) begin
            phase_d = '0;
            done_d  = 1'b1;
`ifdef PHASE_SEQ_ONESHOT_EN
            state_d = ST_HOLD;
`endif
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PHASE_SEQ_ONESHOT_EN
      ST_HOLD: begin
        phase_d = '0;
        cnt_d   = '0;
        if (!req) begin
          state_d = ST_IDLE;
        end else if (req_mode != mode_q) begin
          state_d = ST_RUN;
          mode_d  = req_mode;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        dur_q[i] <= default_dur(i);
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      dur_q   <= dur_d;
    end
  end

  assign phase       = phase_q;
  assign phase_cnt   = cnt_q;
  assign busy        = (state_q == ST_RUN);
  assign mode        = mode_q;
  assign phase_start = busy & (cnt_q == '0);
  assign cycle_done  = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_phase_timing_sequencer.sv
// Bench for phase_timing_sequencer: directed scenarios plus random traffic against a cycle reference model.
module tb_phase_timing_sequencer;
  localparam int NP = 12;
  localparam int CW = 6;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_wr = 1'b0, req_rd = 1'b0, dur_we = 1'b0;
  logic [IW-1:0] dur_addr = '0;
  logic [CW-1:0] dur_data = '0;
  logic [IW-1:0] phase;
  logic [CW-1:0] phase_cnt;
  logic          busy, mode, phase_start, cycle_done;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_mis = 0;

  phase_timing_sequencer #(.NUM_PHASES(NP), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd),
    .dur_we(dur_we), .dur_addr(dur_addr), .dur_data(dur_data),
    .phase(phase), .phase_cnt(phase_cnt), .busy(busy), .mode(mode),
    .phase_start(phase_start), .cycle_done(cycle_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // reference model: sequence position as plain integers
  int m_dur [NP];
  bit m_run, m_hold, m_mode, m_done;
  int m_phase, m_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    int defs [12] = '{20, 20, 20, 10, 10, 20, 60, 20, 10, 10, 50, 10};
    for (int i = 0; i < NP; i++) m_dur[i] = (i < 12) ? defs[i] : 20;
    m_run = 0; m_hold = 0; m_mode = 0; m_done = 0; m_phase = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit wr, input bit rd, input bit we, input int addr, input int data);
    bit req = wr | rd;
    bit rmode = !wr && rd;
    m_done = 0;
    if (m_run) begin
      if (!req) begin
        m_run = 0; m_phase = 0; m_cnt = 0;
      end else if (rmode != m_mode) begin
        m_mode = rmode; m_phase = 0; m_cnt = 0;
      end else if (m_cnt >= m_dur[m_phase]) begin
        m_cnt = 0;
        m_phase = (m_phase + 1) % NP;
        if (m_phase == 0) begin
          m_done = 1;
`ifdef PHASE_SEQ_ONESHOT_EN
          m_run = 0; m_hold = 1;
`endif
        end
      end else begin
        m_cnt++;
      end
    end else if (m_hold) begin
      if (!req) m_hold = 0;
      else if (rmode != m_mode) begin
        m_hold = 0; m_run = 1; m_mode = rmode;
      end
    end else if (req) begin
      m_run = 1; m_mode = rmode; m_phase = 0; m_cnt = 0;
    end
    if (we && addr < NP) m_dur[addr] = data;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".phase"}, int'(phase), m_phase);
    check({tag, ".cnt"}, int'(phase_cnt), m_cnt);
    check({tag, ".busy"}, int'(busy), int'(m_run));
    check({tag, ".mode"}, int'(mode), int'(m_mode));
    check({tag, ".start"}, int'(phase_start), int'(m_run && m_cnt == 0));
    check({tag, ".done"}, int'(cycle_done), int'(m_done));
  endtask

  // one clock edge; inputs are applied by callers between edges
  task automatic step(input string tag);
    bit wr = req_wr, rd = req_rd, we = dur_we;
    int a = int'(dur_addr), d = int'(dur_data);
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(wr, rd, we, a, d);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    compare_all("rst_async");
    step("rst_hold");
    reset = 1'b0;
  endtask

  task automatic run_until(input string tag, input int p, input int c, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step(tag);
      if (int'(phase) == p && int'(phase_cnt) == c) found = 1;
    end
    check({tag, ".reached"}, int'(found), 1);
  endtask

  task automatic write_dur(input int addr, input int data);
    dur_we = 1'b1; dur_addr = IW'(addr); dur_data = CW'(data);
    step("dur_wr");
    dur_we = 1'b0;
  endtask

  initial begin
    int ph0_n, ph6_n, done_n, first_done, second_done;
    model_reset();
    @(posedge clk); #1;
    compare_all("reset");
    reset = 1'b0;

    // full default-length write sequence
    req_wr = 1'b1;
    ph0_n = 0; ph6_n = 0; done_n = 0; first_done = -1; second_done = -1;
    for (int e = 1; e <= 600; e++) begin
      step("seq");
      if (e <= 272 && busy && phase == 0) ph0_n++;
      if (e <= 272 && busy && phase == 6) ph6_n++;
      if (cycle_done) begin
        done_n++;
        if (first_done < 0) first_done = e - 1;
        else if (second_done < 0) second_done = e - 1;
      end
    end
    check("ph0_len", ph0_n, 21);
    check("ph6_len", ph6_n, 61);
    check("first_done_at", first_done, 272);
`ifdef PHASE_SEQ_ONESHOT_EN
    check("done_count", done_n, 1);
    check("busy_after_oneshot", int'(busy), 0);
`else
    check("second_done_at", second_done, 544);
    check("done_count", done_n, 2);
`endif

    // read sequence interrupted by a write request
    req_wr = 1'b0;
    do_reset();
    req_rd = 1'b1;
    run_until("rd_run", 3, 5, 200);
    req_wr = 1'b1;
    step("restart");
    check("restart.phase", int'(phase), 0);
    check("restart.mode", int'(mode), 0);
    check("restart.busy", int'(busy), 1);

    // abort then restart from phase 0
    req_rd = 1'b0;
    run_until("wr_run", 10, 30, 400);
    req_wr = 1'b0;
    step("abort");
    check("abort.busy", int'(busy), 0);
    req_wr = 1'b1;
    step("reassert");
    check("reassert.phase", int'(phase), 0);
    check("reassert.busy", int'(busy), 1);

    // shorten the running phase, then phase 0
    run_until("to_ph6", 6, 40, 300);
    write_dur(6, 5);
    for (int i = 0; i < 3; i++) step("short6");
    write_dur(0, 3);
    for (int i = 0; i < 200; i++) step("short0");

    // asynchronous reset mid-phase
    run_until("to_ph8", 8, 2, 400);
    do_reset();
    check("arst.phase", int'(phase), 0);
    for (int i = 0; i < 60; i++) step("post_rst");

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        req_wr = 1'($urandom_range(0, 1));
        req_rd = ($urandom_range(0, 3) != 0);
      end
      dur_we = ($urandom_range(0, 15) == 0);
      dur_addr = IW'($urandom_range(0, 15));
      dur_data = CW'($urandom_range(0, 6));
      step("rand");
    end
    dur_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
